// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// default geometry, FSM state encodings and the per-line metadata record.
package dcache_pkg;

    localparam int DEF_INDEX_BITS  = 4;
    localparam int DEF_OFFSET_BITS = 2;
    localparam int TAG_BITS        = 32 - DEF_INDEX_BITS - DEF_OFFSET_BITS - 2;

    typedef logic [1:0] state_t;

    localparam state_t IDLE       = 2'd0;
    localparam state_t WRITE_BACK = 2'd1;
    localparam state_t ALLOCATE   = 2'd2;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [TAG_BITS-1:0] tag;
    } line_meta_t;

endpackage

// File: rtl/dcache_line_store.sv
// Cache storage: word-addressed data array with two combinational read ports
// and per-line metadata whose valid/dirty flags clear on reset.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS  = DEF_INDEX_BITS,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [OFFSET_BITS-1:0] rd_word,
    output logic [31:0]            rd_data,
    output line_meta_t             rd_meta,
    input  logic [INDEX_BITS-1:0]  wb_index,
    input  logic [OFFSET_BITS-1:0] wb_word,
    output logic [31:0]            wb_data,
    input  logic                   data_we,
    input  logic [INDEX_BITS-1:0]  data_index,
    input  logic [OFFSET_BITS-1:0] data_word,
    input  logic [31:0]            data_wdata,
    input  logic                   meta_we,
    input  logic [INDEX_BITS-1:0]  meta_index,
    input  line_meta_t             meta_wdata
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;

    logic [31:0]         data_mem [LINES*WORDS];
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [LINES-1:0]    valid_bits;
    logic [LINES-1:0]    dirty_bits;

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[{data_index, data_word}] <= data_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (meta_we) begin
            tag_mem[meta_index] <= meta_wdata.tag;
        end
    end

    // Only the flags are reset; tags and data are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (meta_we) begin
            valid_bits[meta_index] <= meta_wdata.valid;
            dirty_bits[meta_index] <= meta_wdata.dirty;
        end
    end

    assign rd_data       = data_mem[{rd_index, rd_word}];
    assign wb_data       = data_mem[{wb_index, wb_word}];
    assign rd_meta.valid = valid_bits[rd_index];
    assign rd_meta.dirty = dirty_bits[rd_index];
    assign rd_meta.tag   = tag_mem[rd_index];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: hit logic, miss FSM,
// beat counter and latched miss address in front of a word-wide memory port.
module dcache
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS  = DEF_INDEX_BITS,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        hit_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam int TAG_W = 32 - INDEX_BITS - OFFSET_BITS - 2;
    localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;

    // The metadata record is sized from the package defaults.
    if (TAG_W != TAG_BITS) begin : g_geometry_check
        $error("dcache: INDEX_BITS/OFFSET_BITS must match dcache_pkg defaults");
    end

    logic [OFFSET_BITS-1:0] word;
    logic [INDEX_BITS-1:0]  index;
    logic [TAG_BITS-1:0]    tag;
    logic                   unused_addr_bits;

    assign word             = addr_i[OFFSET_BITS+1:2];
    assign index            = addr_i[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
    assign tag              = addr_i[31:INDEX_BITS+OFFSET_BITS+2];
    assign unused_addr_bits = ^addr_i[1:0];

    state_t                 state;
    logic [OFFSET_BITS-1:0] cnt;
    logic [INDEX_BITS-1:0]  miss_index;
    logic [TAG_BITS-1:0]    miss_tag;
    logic [TAG_BITS-1:0]    victim_tag;

    line_meta_t             cur_meta;
    logic [31:0]            wb_data;
    logic                   data_we;
    logic [INDEX_BITS-1:0]  data_index;
    logic [OFFSET_BITS-1:0] data_word;
    logic [31:0]            data_wdata;
    logic                   meta_we;
    logic [INDEX_BITS-1:0]  meta_index;
    line_meta_t             meta_wdata;
    logic                   last_beat;

    dcache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .OFFSET_BITS(OFFSET_BITS)
    ) u_store (
        .clk       (clk_i),
        .rst       (rst_i),
        .rd_index  (index),
        .rd_word   (word),
        .rd_data   (rdata_o),
        .rd_meta   (cur_meta),
        .wb_index  (miss_index),
        .wb_word   (cnt),
        .wb_data   (wb_data),
        .data_we   (data_we),
        .data_index(data_index),
        .data_word (data_word),
        .data_wdata(data_wdata),
        .meta_we   (meta_we),
        .meta_index(meta_index),
        .meta_wdata(meta_wdata)
    );

    assign hit_o     = en_i && (state == IDLE) && cur_meta.valid && (cur_meta.tag == tag);
    assign last_beat = (cnt == LAST_WORD);

    // Memory-side outputs derive only from registers, so they hold until accepted.
    assign mem_req_o   = (state == WRITE_BACK) || (state == ALLOCATE);
    assign mem_we_o    = (state == WRITE_BACK);
    assign mem_addr_o  = {(state == WRITE_BACK) ? victim_tag : miss_tag, miss_index, cnt, 2'b00};
    assign mem_wdata_o = wb_data;

    always_comb begin
        data_we    = 1'b0;
        data_index = index;
        data_word  = word;
        data_wdata = wdata_i;
        meta_we    = 1'b0;
        meta_index = index;
        meta_wdata = cur_meta;
        if (!rst_i) begin
            if (hit_o && we_i) begin
                data_we          = 1'b1;
                meta_we          = 1'b1;
                meta_wdata.dirty = 1'b1;
            end
            if ((state == WRITE_BACK) && mem_ready_i && last_beat) begin
                meta_we    = 1'b1;
                meta_index = miss_index;
                meta_wdata = '{valid: 1'b1, dirty: 1'b0, tag: victim_tag};
            end
            if ((state == ALLOCATE) && mem_ready_i) begin
                data_we    = 1'b1;
                data_index = miss_index;
                data_word  = cnt;
                data_wdata = mem_rdata_i;
                if (last_beat) begin
                    meta_we    = 1'b1;
                    meta_index = miss_index;
                    meta_wdata = '{valid: 1'b1, dirty: 1'b0, tag: miss_tag};
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_i && !hit_o) begin
                        cnt   <= '0;
                        state <= (cur_meta.valid && cur_meta.dirty) ? WRITE_BACK : ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (mem_ready_i) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            state <= ALLOCATE;
                        end
                    end
                end
                ALLOCATE: begin
                    if (mem_ready_i) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Miss address and victim tag are captured when a miss leaves IDLE.
    always_ff @(posedge clk_i) begin
        if ((state == IDLE) && en_i && !hit_o) begin
            miss_index <= index;
            miss_tag   <= tag;
            victim_tag <= cur_meta.tag;
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus randomized accesses
// compared against a flat-memory / line-table reference model.
module tb_dcache;

    logic        clk_i;
    logic        rst_i;
    logic        en_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        hit_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       obs_q[$];
    beat_t       exp_q[$];
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] arch      [logic [31:0]];
    bit          ref_valid [16];
    bit          ref_dirty [16];
    logic [31:0] ref_tag   [16];
    int          rdy_mode;
    bit          manual_ready;
    bit          resp_ready;

    dcache dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .hit_o      (hit_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ready_i(mem_ready_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return mem_init(a);
    endfunction

    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        if (arch.exists(a)) return arch[a];
        return mem_rd(a);
    endfunction

    // Reset loses cached data, so the visible memory becomes main memory again.
    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
        arch.delete();
    endfunction

    function automatic void model_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                                         output bit exp_hit, output logic [31:0] exp_data);
        logic [31:0] a;
        logic [31:0] base;
        logic [31:0] vbase;
        logic [31:0] tg;
        int          idx;
        a    = addr & ~32'h3;
        base = a & ~32'hF;
        idx  = int'((a >> 4) & 32'hF);
        tg   = a >> 8;
        exp_q.delete();
        exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
        if (!exp_hit) begin
            if (ref_valid[idx] && ref_dirty[idx]) begin
                vbase = (ref_tag[idx] << 8) | (32'(idx) << 4);
                for (int k = 0; k < 4; k++)
                    exp_q.push_back('{1'b1, vbase + 32'(k * 4), arch_rd(vbase + 32'(k * 4))});
            end
            for (int k = 0; k < 4; k++)
                exp_q.push_back('{1'b0, base + 32'(k * 4), 32'h0});
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
            ref_tag[idx]   = tg;
        end
        if (we) begin
            arch[a]        = wd;
            ref_dirty[idx] = 1'b1;
        end
        exp_data = arch_rd(a);
    endfunction

    function automatic int beat_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (obs_q[i].we != exp_q[i].we || obs_q[i].addr !== exp_q[i].addr ||
                (exp_q[i].we && obs_q[i].data !== exp_q[i].data))
                return i;
        end
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic string beat_str(input beat_t b);
        return $sformatf("%s@%08h=%08h", b.we ? "W" : "R", b.addr, b.data);
    endfunction

    function automatic string diff_str(input int d);
        string o;
        string e;
        o = (d < obs_q.size()) ? beat_str(obs_q[d]) : "none";
        e = (d < exp_q.size()) ? beat_str(exp_q[d]) : "none";
        return $sformatf("first diff at beat %0d: got %0d beats (%s), expected %0d beats (%s)",
                         d, obs_q.size(), o, exp_q.size(), e);
    endfunction

    // Memory responder: decides ready per cycle and records accepted beats.
    initial begin
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            #2;
            case (rdy_mode)
                0:       resp_ready = 1'b1;
                1:       resp_ready = ($urandom_range(0, 1) == 1);
                default: resp_ready = manual_ready;
            endcase
            mem_ready_i = resp_ready;
            mem_rdata_i = $urandom;
            if (resp_ready && mem_req_o === 1'b1) begin
                if (mem_we_o === 1'b1) begin
                    mem_model[mem_addr_o] = mem_wdata_o;
                    obs_q.push_back('{1'b1, mem_addr_o, mem_wdata_o});
                end else begin
                    mem_rdata_i = mem_rd(mem_addr_o);
                    obs_q.push_back('{1'b0, mem_addr_o, mem_rdata_i});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cpu_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output int cycles, output bit timeout);
        obs_q.delete();
        @(negedge clk_i);
        en_i    = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wd;
        cycles  = 0;
        timeout = 1'b0;
        rd      = '0;
        forever begin
            #1;
            if (hit_o === 1'b1) begin
                rd = rdata_o;
                break;
            end
            cycles++;
            if (cycles > 300) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        en_i = 1'b0;
        we_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        rdy_mode = 0; manual_ready = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++;
        if (hit_o !== 1'b0) begin errors++; $display("[TB] FAIL reset hit_o: got %b, expected 0", hit_o); end
        checks++;
        if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset mem_req_o: got %b, expected 0", mem_req_o); end
        checks++;
        if (mem_we_o !== 1'b0) begin errors++; $display("[TB] FAIL reset mem_we_o: got %b, expected 0", mem_we_o); end
        en_i   = 1'b1;
        addr_i = $urandom;
        #1;
        checks++;
        if (hit_o !== 1'b0) begin errors++; $display("[TB] FAIL reset invalid lines: hit_o got %b, expected 0", hit_o); end
        en_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_load_miss();
        logic [31:0] rd, ed;
        int          cyc, d;
        bit          to, eh;
        mem_model[32'h40] = 32'h11;
        mem_model[32'h44] = 32'h22;
        mem_model[32'h48] = 32'h33;
        mem_model[32'h4C] = 32'h44;
        rdy_mode = 0;
        model_access(1'b0, 32'h40, '0, eh, ed);
        cpu_access(1'b0, 32'h40, '0, rd, cyc, to);
        checks++;
        if (to || cyc != 5) begin errors++; $display("[TB] FAIL load_miss latency: got %0d cycles (timeout %b), expected 5", cyc, to); end
        d = beat_diff();
        checks++;
        if (d != -1) begin errors++; $display("[TB] FAIL load_miss beats: %s", diff_str(d)); end
        checks++;
        if (rd !== 32'h11) begin errors++; $display("[TB] FAIL load_miss rdata: got %08h, expected 00000011", rd); end
    endtask

    task automatic test_store_hit();
        logic [31:0] rd, ed;
        int          cyc;
        bit          to, eh;
        model_access(1'b1, 32'h44, 32'hDEADBEEF, eh, ed);
        cpu_access(1'b1, 32'h44, 32'hDEADBEEF, rd, cyc, to);
        checks++;
        if (to || cyc != 0 || obs_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL store_hit: got %0d stall cycles and %0d beats, expected 0 and 0", cyc, obs_q.size());
        end
        model_access(1'b0, 32'h44, '0, eh, ed);
        cpu_access(1'b0, 32'h44, '0, rd, cyc, to);
        checks++;
        if (to || cyc != 0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL store_then_load: got %08h after %0d cycles, expected deadbeef after 0", rd, cyc);
        end
    endtask

    task automatic test_dirty_evict();
        logic [31:0] rd, ed;
        int          cyc, d;
        bit          to, eh;
        rdy_mode = 0;
        model_access(1'b0, 32'h140, '0, eh, ed);
        cpu_access(1'b0, 32'h140, '0, rd, cyc, to);
        checks++;
        if (to || cyc != 9) begin errors++; $display("[TB] FAIL dirty_evict latency: got %0d cycles (timeout %b), expected 9", cyc, to); end
        d = beat_diff();
        checks++;
        if (d != -1) begin errors++; $display("[TB] FAIL dirty_evict beats: %s", diff_str(d)); end
        checks++;
        if (obs_q.size() < 2 || obs_q[1].data !== 32'hDEADBEEF || obs_q[1].addr !== 32'h44) begin
            errors++;
            $display("[TB] FAIL dirty_evict stored word: got %0d beats, beat1 %s, expected W@00000044=deadbeef",
                     obs_q.size(), (obs_q.size() > 1) ? beat_str(obs_q[1]) : "none");
        end
        checks++;
        if (rd !== ed) begin errors++; $display("[TB] FAIL dirty_evict rdata: got %08h, expected %08h", rd, ed); end
    endtask

    task automatic test_stall();
        logic [31:0] rd, ed, s_addr;
        bit          eh, got;
        int          d;
        rdy_mode = 2;
        manual_ready = 1'b0;
        model_access(1'b0, 32'h280, '0, eh, ed);
        obs_q.delete();
        @(negedge clk_i);
        en_i = 1'b1; we_i = 1'b0; addr_i = 32'h280;
        #1;
        checks++;
        if (hit_o !== 1'b0) begin errors++; $display("[TB] FAIL stall miss hit_o: got %b, expected 0", hit_o); end
        repeat (2) begin
            @(negedge clk_i);
            manual_ready = 1'b1;
        end
        @(negedge clk_i);
        manual_ready = 1'b0;
        #3;
        s_addr = mem_addr_o;
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || s_addr !== 32'h288) begin
            errors++;
            $display("[TB] FAIL stall beat: got req=%b we=%b addr=%08h, expected req=1 we=0 addr=00000288",
                     mem_req_o, mem_we_o, s_addr);
        end
        repeat (4) begin
            @(negedge clk_i);
            #3;
            checks++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h288) begin
                errors++;
                $display("[TB] FAIL stall hold: got req=%b we=%b addr=%08h, expected req=1 we=0 addr=00000288",
                         mem_req_o, mem_we_o, mem_addr_o);
            end
        end
        checks++;
        if (obs_q.size() != 2) begin errors++; $display("[TB] FAIL stall beat count: got %0d, expected 2", obs_q.size()); end
        got = 1'b0;
        rd  = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            manual_ready = 1'b1;
            #1;
            if (hit_o === 1'b1) begin
                rd  = rdata_o;
                got = 1'b1;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        en_i = 1'b0;
        manual_ready = 1'b0;
        rdy_mode = 0;
        d = beat_diff();
        checks++;
        if (!got || d != -1) begin errors++; $display("[TB] FAIL stall fill: hit %b, %s", got, diff_str(d)); end
        checks++;
        if (rd !== ed) begin errors++; $display("[TB] FAIL stall rdata: got %08h, expected %08h", rd, ed); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd, ed;
        int          cyc, d;
        bit          to, eh;
        rdy_mode = 2;
        manual_ready = 1'b0;
        obs_q.delete();
        @(negedge clk_i);
        en_i = 1'b1; we_i = 1'b0; addr_i = 32'h40;
        @(negedge clk_i);
        manual_ready = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        manual_ready = 1'b0;
        rst_i = 1'b1;
        en_i  = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #3;
        checks++;
        if (mem_req_o !== 1'b0 || obs_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL reset_mid_fill: got req=%b after %0d beats, expected req=0 after 2", mem_req_o, obs_q.size());
        end
        model_reset();
        rdy_mode = 0;
        model_access(1'b0, 32'h40, '0, eh, ed);
        cpu_access(1'b0, 32'h40, '0, rd, cyc, to);
        d = beat_diff();
        checks++;
        if (to || cyc != 5 || d != -1) begin
            errors++;
            $display("[TB] FAIL reset_refetch: %0d cycles (expected 5), %s", cyc, diff_str(d));
        end
        checks++;
        if (rd !== 32'h11) begin errors++; $display("[TB] FAIL reset_refetch rdata: got %08h, expected 00000011", rd); end
    endtask

    task automatic test_idle();
        logic [31:0] rd, ed;
        int          cyc;
        bit          to, eh;
        rdy_mode = 2;
        obs_q.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            en_i = 1'b0;
            we_i = 1'($urandom_range(0, 1));
            addr_i  = $urandom;
            wdata_i = $urandom;
            manual_ready = 1'($urandom_range(0, 1));
            #3;
            checks++;
            if (hit_o !== 1'b0 || mem_req_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle: got hit=%b req=%b, expected 0 and 0", hit_o, mem_req_o);
            end
        end
        we_i = 1'b0;
        manual_ready = 1'b0;
        rdy_mode = 0;
        model_access(1'b0, 32'h48, '0, eh, ed);
        cpu_access(1'b0, 32'h48, '0, rd, cyc, to);
        checks++;
        if (to || cyc != 0 || rd !== ed || obs_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL idle state kept: got %08h after %0d cycles with %0d beats, expected %08h after 0 with 0",
                     rd, cyc, obs_q.size(), ed);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, ed, addr, wd;
        int          cyc, d, need;
        bit          to, eh, we;
        for (int n = 0; n < 150; n++) begin
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            addr = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
                   (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            rdy_mode = $urandom_range(0, 1);
            model_access(we, addr, wd, eh, ed);
            need = eh ? 0 : 1 + exp_q.size();
            cpu_access(we, addr, wd, rd, cyc, to);
            d = beat_diff();
            checks++;
            if (d != -1) begin errors++; $display("[TB] FAIL random[%0d] beats addr %08h: %s", n, addr, diff_str(d)); end
            checks++;
            if (to || (rdy_mode == 0 && cyc != need) || cyc < need) begin
                errors++;
                $display("[TB] FAIL random[%0d] latency addr %08h: got %0d cycles (timeout %b), expected %0d (mode %0d)",
                         n, addr, cyc, to, need, rdy_mode);
            end
            if (!we) begin
                checks++;
                if (rd !== ed) begin errors++; $display("[TB] FAIL random[%0d] rdata addr %08h: got %08h, expected %08h", n, addr, rd, ed); end
            end
        end
        rdy_mode = 0;
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_store_hit();
        test_dirty_evict();
        test_stall();
        test_reset_mid_fill();
        test_idle();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
